// File: rtl/mul_issue_scheduler_pkg.sv
// Shared widths, latency and record types for the multiply issue path.
// MUL_LAT is tied to the register depth of the shift-add multiplier.
package mul_issue_scheduler_pkg;

    localparam int N_REQ      = 4;
    localparam int TAG_W      = 4;
    localparam int DATA_W     = 32;
    localparam int MUL_LAT    = 6;
    localparam int FIFO_DEPTH = 4;

    localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] data_t;

    // One shadow stage: mirrors a multiplier stage.
    typedef struct packed {
        logic valid;
        tag_t tag;
    } shadow_t;

    // One buffered CDB result.
    typedef struct packed {
        tag_t  tag;
        data_t data;
    } cdb_entry_t;

    function automatic logic [RR_W-1:0] rr_next(
        input logic [RR_W-1:0] k
    );
        return (k == RR_W'(N_REQ - 1)) ? '0 : k + RR_W'(1);
    endfunction

endpackage

// File: rtl/mul_issue_scheduler_if.sv
// Bundle between the scheduler, the RS entries, the multiplier and the CDB.
// master: scheduler side. slave: RS/multiplier/CDB side.
interface mul_issue_scheduler_if;
    import mul_issue_scheduler_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ-1:0]        grant;

    logic                    mul_en;
    data_t                   mul_a;
    data_t                   mul_b;
    data_t                   mul_result;

    logic                    cdb_valid;
    tag_t                    cdb_tag;
    data_t                   cdb_data;
    logic                    cdb_ack;

    logic [CNT_W-1:0]        outstanding;

    modport master (
        input  req_valid, req_tag, req_a, req_b,
        input  mul_result, cdb_ack,
        output grant, mul_en, mul_a, mul_b,
        output cdb_valid, cdb_tag, cdb_data,
        output outstanding
    );

    modport slave (
        output req_valid, req_tag, req_a, req_b,
        output mul_result, cdb_ack,
        input  grant, mul_en, mul_a, mul_b,
        input  cdb_valid, cdb_tag, cdb_data,
        input  outstanding
    );

endinterface

// File: rtl/mul_issue_scheduler_result_fifo.sv
// mul_result_fifo: synchronous {tag, data} result buffer.
// Ports: clk, RST, push/din, pop/dout (head), full, empty, count.
module mul_result_fifo
    import mul_issue_scheduler_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       push,
    input  cdb_entry_t                 din,
    input  logic                       pop,
    output cdb_entry_t                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    cdb_entry_t      mem [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic            do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop request against an empty buffer is dropped here.
    assign do_pop = pop && !empty;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (RST) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= nxt(wp);
            end
            if (do_pop) begin
                rp <= nxt(rp);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_push_full: assert property (
        @(posedge clk) disable iff (RST)
        !(push && full)
    );

endmodule

// File: rtl/mul_issue_scheduler.sv
// Round-robin issue into the pipelined multiplier, shadow tag pipe,
// credit counter and CDB result buffer.
// Ports: clk, RST (sync, active-high), bus (master side of the bundle).
module mul_issue_scheduler
    import mul_issue_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  RST,
    mul_issue_scheduler_if.master bus
);

    logic [RR_W-1:0]  rr;
    logic [RR_W-1:0]  gidx;
    logic             found;
    int               scan;
    logic             issue;
    tag_t             gtag;

    shadow_t          sh [MUL_LAT];
    logic             push;
    logic             pop;

    logic [CNT_W-1:0] credit_used;
    logic [CNT_W-1:0] fcount;
    logic             full;
    logic             empty;
    cdb_entry_t       head;
    cdb_entry_t       din;

    // Scan from rr, wrapping, for the first ready entry.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        scan  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan = int'(rr) + i;
            if (scan >= N_REQ) begin
                scan = scan - N_REQ;
            end
            if (!found && bus.req_valid[scan]) begin
                found = 1'b1;
                gidx  = RR_W'(scan);
            end
        end
    end

    // Credits count in-flight plus buffered results.
    assign issue = found
        && (credit_used < CNT_W'(FIFO_DEPTH));

    always_comb begin
        bus.grant  = '0;
        bus.mul_a  = '0;
        bus.mul_b  = '0;
        gtag       = '0;
        if (issue) begin
            bus.grant[gidx] = 1'b1;
            bus.mul_a = bus.req_a[int'(gidx)*DATA_W +: DATA_W];
            bus.mul_b = bus.req_b[int'(gidx)*DATA_W +: DATA_W];
            gtag      = bus.req_tag[int'(gidx)*TAG_W +: TAG_W];
        end
    end

    assign bus.mul_en = issue;

    // Shifts every cycle, like the multiplier's own stages.
    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                sh[i] <= '0;
            end
        end else begin
            sh[0] <= {issue, gtag};
            for (int i = 1; i < MUL_LAT; i++) begin
                sh[i] <= sh[i-1];
            end
        end
    end

    assign push = sh[MUL_LAT-1].valid;
    assign din  = {sh[MUL_LAT-1].tag, bus.mul_result};
    assign pop  = !empty && bus.cdb_ack;

    always_ff @(posedge clk) begin
        if (RST) begin
            rr          <= '0;
            credit_used <= '0;
        end else begin
            if (issue) begin
                rr <= rr_next(gidx);
            end
            case ({issue, pop})
                2'b10:   credit_used <= credit_used + CNT_W'(1);
                2'b01:   credit_used <= credit_used - CNT_W'(1);
                default: credit_used <= credit_used;
            endcase
        end
    end

    mul_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .RST   (RST),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fcount)
    );

    assign bus.cdb_valid   = !empty;
    assign bus.cdb_tag     = head.tag;
    assign bus.cdb_data    = head.data;
    assign bus.outstanding = credit_used;

    a_grant_onehot: assert property (
        @(posedge clk) disable iff (RST)
        $onehot0(bus.grant)
    );

    a_credit_bound: assert property (
        @(posedge clk) disable iff (RST)
        credit_used <= CNT_W'(FIFO_DEPTH)
    );

    // Buffered results are always a subset of the credits in use.
    a_buf_le_credit: assert property (
        @(posedge clk) disable iff (RST)
        fcount <= credit_used
    );

    a_full_no_credit: assert property (
        @(posedge clk) disable iff (RST)
        full |-> (credit_used == CNT_W'(FIFO_DEPTH))
    );

endmodule

// File: tb/tb_mul_issue_scheduler.sv
// Directed bench for mul_issue_scheduler with a behavioural
// multiplier pipe and an expected-result queue for the CDB.
module tb_mul_issue_scheduler;
    import mul_issue_scheduler_pkg::*;

    logic clk;
    logic RST;

    mul_issue_scheduler_if bus ();

    mul_issue_scheduler dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product visible MUL_LAT edges after EN.
    logic [31:0] mpipe [MUL_LAT];

    always_ff @(posedge clk) begin
        mpipe[0] <= bus.mul_en ? (bus.mul_a * bus.mul_b)
                               : 32'hDEAD_BEEF;
        for (int i = 1; i < MUL_LAT; i++) begin
            mpipe[i] <= mpipe[i-1];
        end
    end

    assign bus.mul_result = mpipe[MUL_LAT-1];

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
    } res_t;

    res_t exp_q [$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h",
                     nm, act, exp);
        end
    endtask

    // Every accepted CDB beat must match the next expected result.
    always @(negedge clk) begin
        if (RST) begin
            exp_q.delete();
        end else if (bus.cdb_valid && bus.cdb_ack) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_extra: got tag 0x%0h, want none",
                         bus.cdb_tag);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("sb_tag", 64'(bus.cdb_tag), 64'(e.tag));
                chk("sb_data", 64'(bus.cdb_data), 64'(e.data));
            end
        end
    end

    typedef struct {
        int          e;
        logic [3:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  g;
        logic [31:0] p;
    } vec_t;

    vec_t vt [5];

    logic [3:0]  rtag [4];
    logic [31:0] rprd [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic set_all();
        for (int i = 0; i < 4; i++) begin
            bus.req_tag[i*4 +: 4]  = 4'(8 + i);
            bus.req_a[i*32 +: 32]  = 32'(i + 1);
            bus.req_b[i*32 +: 32]  = 32'(100 + i);
        end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        bus.cdb_ack = 1'b1;
        while (exp_q.size() != 0 && k < 60) begin
            tick();
            k++;
        end
        chk(nm, 64'(exp_q.size()), 64'd0);
        bus.cdb_ack = 1'b0;
        @(negedge clk);
        chk({nm, "_outst"}, 64'(bus.outstanding), 64'd0);
        chk({nm, "_valid"}, 64'(bus.cdb_valid), 64'd0);
        tick();
    endtask

    task automatic run_vec(input vec_t x, input int v);
        int lat;
        bit got;
        string nm;
        nm = $sformatf("vec%0d", v);
        bus.req_valid = '0;
        bus.req_valid[x.e] = 1'b1;
        bus.req_tag[x.e*4 +: 4] = x.tag;
        bus.req_a[x.e*32 +: 32] = x.a;
        bus.req_b[x.e*32 +: 32] = x.b;
        exp_q.push_back({x.tag, x.p});
        @(negedge clk);
        chk({nm, "_grant"}, 64'(bus.grant), 64'(x.g));
        chk({nm, "_en"}, 64'(bus.mul_en), 64'd1);
        chk({nm, "_a"}, 64'(bus.mul_a), 64'(x.a));
        chk({nm, "_b"}, 64'(bus.mul_b), 64'(x.b));
        tick();
        bus.req_valid = '0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.cdb_valid) got = 1'b1;
        end
        chk({nm, "_lat"}, 64'(lat), 64'd7);
        chk({nm, "_tag"}, 64'(bus.cdb_tag), 64'(x.tag));
        chk({nm, "_data"}, 64'(bus.cdb_data), 64'(x.p));
        chk({nm, "_outst1"}, 64'(bus.outstanding), 64'd1);
        tick();
        bus.cdb_ack = 1'b1;
        tick();
        bus.cdb_ack = 1'b0;
        @(negedge clk);
        chk({nm, "_valid0"}, 64'(bus.cdb_valid), 64'd0);
        chk({nm, "_outst0"}, 64'(bus.outstanding), 64'd0);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        int gcyc [5];

        vt[0] = '{e:2, tag:4'h5, a:32'd7, b:32'd6,
                  g:4'b0100, p:32'd42};
        vt[1] = '{e:0, tag:4'h1, a:32'hFFFF_FFFF, b:32'd2,
                  g:4'b0001, p:32'hFFFF_FFFE};
        vt[2] = '{e:3, tag:4'hF, a:32'd0, b:32'h1234_5678,
                  g:4'b1000, p:32'd0};
        vt[3] = '{e:1, tag:4'h3, a:32'h0001_0000,
                  b:32'h0001_0000, g:4'b0010, p:32'd0};
        vt[4] = '{e:1, tag:4'hA, a:32'h0000_1234, b:32'h10,
                  g:4'b0010, p:32'h0001_2340};

        rtag = '{4'h8, 4'h9, 4'hA, 4'hB};
        rprd = '{32'd100, 32'd202, 32'd306, 32'd412};

        RST           = 1'b1;
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.cdb_ack   = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_en", 64'(bus.mul_en), 64'd0);
        chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_outst", 64'(bus.outstanding), 64'd0);
        chk("rst_tag", 64'(bus.cdb_tag), 64'd0);
        chk("rst_data", 64'(bus.cdb_data), 64'd0);
        chk("rst_mul_a", 64'(bus.mul_a), 64'd0);
        tick();
        RST = 1'b0;
        tick();

        // Single issues and arithmetic corners
        for (int v = 0; v < 5; v++) begin
            run_vec(vt[v], v);
        end

        // Round-robin with ack held high
        do_reset();
        set_all();
        bus.cdb_ack   = 1'b1;
        bus.req_valid = 4'hF;
        n = 0;
        cyc = 0;
        while (n < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.grant != '0) begin
                chk($sformatf("rr_grant%0d", n),
                    64'(bus.grant), 64'(4'b0001 << (n % 4)));
                exp_q.push_back({rtag[n%4], rprd[n%4]});
                gcyc[n] = cyc;
                n++;
            end
            tick();
            if (n == 5) bus.req_valid = '0;
        end
        bus.req_valid = '0;
        chk("rr_count", 64'(n), 64'd5);
        if (n == 5) begin
            chk("rr_burst", 64'(gcyc[3] - gcyc[0]), 64'd3);
            chk("rr_5th", 64'(gcyc[4] - gcyc[0]), 64'd8);
        end
        drain("rr_drain");

        // Backpressure: credits run out at FIFO_DEPTH
        do_reset();
        set_all();
        bus.cdb_ack   = 1'b0;
        bus.req_valid = 4'hF;
        n = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (bus.grant != '0) begin
                if (n < 4) begin
                    chk($sformatf("bp_grant%0d", n),
                        64'(bus.grant), 64'(4'b0001 << n));
                    exp_q.push_back({rtag[n], rprd[n]});
                end
                n++;
            end
            tick();
        end
        @(negedge clk);
        chk("bp_count", 64'(n), 64'd4);
        chk("bp_grant0", 64'(bus.grant), 64'd0);
        chk("bp_outst", 64'(bus.outstanding), 64'd4);
        chk("bp_valid", 64'(bus.cdb_valid), 64'd1);
        chk("bp_tag", 64'(bus.cdb_tag), 64'h8);
        chk("bp_data", 64'(bus.cdb_data), 64'd100);
        tick();
        bus.cdb_ack = 1'b1;
        @(negedge clk);
        chk("bp_ack_grant", 64'(bus.grant), 64'd0);
        tick();
        bus.cdb_ack = 1'b0;
        @(negedge clk);
        chk("bp_regrant", 64'(bus.grant), 64'b0001);
        chk("bp_outst3", 64'(bus.outstanding), 64'd3);
        exp_q.push_back({rtag[0], rprd[0]});
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("bp_stall", 64'(bus.grant), 64'd0);
        chk("bp_outst4", 64'(bus.outstanding), 64'd4);
        chk("bp_hold_tag", 64'(bus.cdb_tag), 64'h9);
        tick();
        drain("bp_drain");

        // Simultaneous push and pop with 3 buffered
        do_reset();
        set_all();
        bus.cdb_ack   = 1'b0;
        bus.req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({rtag[i], rprd[i]});
        end
        repeat (4) tick();
        bus.req_valid = '0;
        repeat (5) tick();
        bus.cdb_ack = 1'b1;
        @(negedge clk);
        chk("pp_occ_before", 64'(dut.u_fifo.count), 64'd3);
        chk("pp_outst_before", 64'(bus.outstanding), 64'd4);
        tick();
        @(negedge clk);
        chk("pp_occ_after", 64'(dut.u_fifo.count), 64'd3);
        chk("pp_outst_after", 64'(bus.outstanding), 64'd3);
        tick();
        drain("pp_drain");

        // Reset with three operations in flight
        do_reset();
        set_all();
        bus.cdb_ack   = 1'b1;
        bus.req_valid = 4'b0111;
        repeat (3) tick();
        bus.req_valid = '0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int c = 0; c < MUL_LAT + 2; c++) begin
            @(negedge clk);
            chk($sformatf("mr_valid%0d", c),
                64'(bus.cdb_valid), 64'd0);
            tick();
        end
        chk("mr_outst", 64'(bus.outstanding), 64'd0);
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("mr_rr0", 64'(bus.grant), 64'b0001);
        exp_q.push_back({rtag[0], rprd[0]});
        tick();
        bus.req_valid = '0;
        drain("mr_drain");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
